// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU,
// branch/jump resolution for fetch, and the EX/MEM pipeline register.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [4:0]  regbits_t;

  localparam aluop_t ALU_SLL  = 4'b0000;
  localparam aluop_t ALU_SRL  = 4'b0001;
  localparam aluop_t ALU_ADD  = 4'b0010;
  localparam aluop_t ALU_SUB  = 4'b0011;
  localparam aluop_t ALU_AND  = 4'b0100;
  localparam aluop_t ALU_OR   = 4'b0101;
  localparam aluop_t ALU_XOR  = 4'b0110;
  localparam aluop_t ALU_NOR  = 4'b0111;
  localparam aluop_t ALU_SLT  = 4'b1010;
  localparam aluop_t ALU_SLTU = 4'b1011;

  localparam opcode_t OP_BEQ = 6'b000100;
  localparam opcode_t OP_BNE = 6'b000101;
endpackage

// EX/MEM register control: RST clears everything; flush loads a bubble
// regardless of enable; enable=1 loads the computed values; enable=0 holds.
// exmem_halt is sticky: once set, only RST clears it.
module execute_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     enable,
  input  logic     flush,
  input  word_t    inst,
  input  word_t    rdat1,
  input  word_t    rdat2,
  input  word_t    extended_value,
  input  word_t    shamt_value,
  input  word_t    lui_value,
  input  word_t    pc_next,
  input  opcode_t  op,
  input  aluop_t   ALUOp,
  input  logic [1:0] jump,
  input  logic     lui,
  input  logic     branch,
  input  logic     MemToReg,
  input  logic     shamt,
  input  logic     ALUSrc,
  input  logic     RegDst,
  input  logic     halt,
  input  logic     dWEN,
  input  logic     dREN,
  input  logic     RegWrite,
  input  logic [1:0] fwdA,
  input  logic [1:0] fwdB,
  input  word_t    mem_fwd_data,
  input  word_t    wb_fwd_data,
  output logic     pc_src,
  output word_t    pc_target,
  output word_t    exmem_result,
  output word_t    exmem_store_data,
  output word_t    exmem_pc_next,
  output regbits_t exmem_wsel,
  output logic     exmem_MemToReg,
  output logic     exmem_RegWrite,
  output logic     exmem_dWEN,
  output logic     exmem_dREN,
  output logic     exmem_halt,
  output logic     exmem_zero
);

  word_t    opa, fwd_b, portb, alu_res, result;
  word_t    branch_target, jump_target;
  regbits_t wsel;
  logic     branch_taken;

  word_t    result_q, result_d, store_q, store_d, pcn_q, pcn_d;
  regbits_t wsel_q, wsel_d;
  logic     m2r_q, m2r_d, rw_q, rw_d, wen_q, wen_d, ren_q, ren_d;
  logic     halt_q, halt_d, zero_q, zero_d;

  // Only the jump index and register fields of inst are used here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:26];

  // Forwarding muxes; select 11 is reserved and behaves like 00.
  always_comb begin
    opa = rdat1;
    case (fwdA)
      2'b01:   opa = mem_fwd_data;
      2'b10:   opa = wb_fwd_data;
      default: opa = rdat1;
    endcase
    fwd_b = rdat2;
    case (fwdB)
      2'b01:   fwd_b = mem_fwd_data;
      2'b10:   fwd_b = wb_fwd_data;
      default: fwd_b = rdat2;
    endcase
  end

  // ALU port B select: shift amount beats immediate beats register.
  always_comb begin
    portb = fwd_b;
    if (shamt)       portb = shamt_value;
    else if (ALUSrc) portb = extended_value;
  end

  // ALU evaluation; undefined operations yield zero.
  always_comb begin
    alu_res = '0;
    case (ALUOp)
      ALU_SLL:  alu_res = shamt ? (opa << portb[4:0]) : (portb << opa[4:0]);
      ALU_SRL:  alu_res = shamt ? (opa >> portb[4:0]) : (portb >> opa[4:0]);
      ALU_ADD:  alu_res = opa + portb;
      ALU_SUB:  alu_res = opa - portb;
      ALU_AND:  alu_res = opa & portb;
      ALU_OR:   alu_res = opa | portb;
      ALU_XOR:  alu_res = opa ^ portb;
      ALU_NOR:  alu_res = ~(opa | portb);
      ALU_SLT:  alu_res = {31'b0, ($signed(opa) < $signed(portb))};
      ALU_SLTU: alu_res = {31'b0, (opa < portb)};
      default:  alu_res = '0;
    endcase
  end

  // Writeback value and destination register selection.
  always_comb begin
    result = alu_res;
    if (jump == 2'b10) result = pc_next;
    else if (lui)      result = lui_value;
    wsel = inst[20:16];
    if (jump == 2'b10) wsel = 5'd31;
    else if (RegDst)   wsel = inst[15:11];
  end

  // Branch/jump resolution for fetch; a jump overrides a taken branch.
  always_comb begin
    branch_taken  = branch && (((op == OP_BEQ) && (opa == fwd_b)) ||
                               ((op == OP_BNE) && (opa != fwd_b)));
    branch_target = pc_next + {extended_value[29:0], 2'b00};
    jump_target   = (jump == 2'b11) ? opa : {pc_next[31:28], inst[25:0], 2'b00};
    pc_src        = branch_taken || (jump != 2'b00);
    pc_target     = (jump != 2'b00) ? jump_target : branch_target;
  end

  // EX/MEM next state: bubble on flush, load on enable, otherwise hold.
  always_comb begin
    result_d = result_q; store_d = store_q; pcn_d = pcn_q; wsel_d = wsel_q;
    m2r_d = m2r_q; rw_d = rw_q; wen_d = wen_q; ren_d = ren_q; zero_d = zero_q;
    if (flush) begin
      result_d = '0; store_d = '0; pcn_d = '0; wsel_d = '0;
      m2r_d = 1'b0; rw_d = 1'b0; wen_d = 1'b0; ren_d = 1'b0; zero_d = 1'b0;
    end else if (enable) begin
      result_d = result; store_d = fwd_b; pcn_d = pc_next; wsel_d = wsel;
      m2r_d = MemToReg; rw_d = RegWrite; wen_d = dWEN; ren_d = dREN;
      zero_d = (alu_res == '0);
    end
    halt_d = halt_q | (!flush && enable && halt);
  end

  // EX/MEM register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= '0; store_q <= '0; pcn_q <= '0; wsel_q <= '0;
      m2r_q <= 1'b0; rw_q <= 1'b0; wen_q <= 1'b0; ren_q <= 1'b0;
      halt_q <= 1'b0; zero_q <= 1'b0;
    end else begin
      result_q <= result_d; store_q <= store_d; pcn_q <= pcn_d; wsel_q <= wsel_d;
      m2r_q <= m2r_d; rw_q <= rw_d; wen_q <= wen_d; ren_q <= ren_d;
      halt_q <= halt_d; zero_q <= zero_d;
    end
  end

  assign exmem_result     = result_q;
  assign exmem_store_data = store_q;
  assign exmem_pc_next    = pcn_q;
  assign exmem_wsel       = wsel_q;
  assign exmem_MemToReg   = m2r_q;
  assign exmem_RegWrite   = rw_q;
  assign exmem_dWEN       = wen_q;
  assign exmem_dREN       = ren_q;
  assign exmem_halt       = halt_q;
  assign exmem_zero       = zero_q;

endmodule
